// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter with a held request and an inter-byte gap
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

    state_t            state, state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0]     gap_cnt;
    logic              wr_accept, pop, launch, gap_load;
    logic [ADDR_W:0]   count_next;

    // Acceptance uses the registered full flag, so a same-cycle pop never frees a slot.
    assign wr_accept  = wr_en && !full;
    assign count_next = count + (ADDR_W+1)'(wr_accept) - (ADDR_W+1)'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        launch     = 1'b0;
        gap_load   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy && gap_cnt == '0) begin
                    launch     = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    pop        = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_load   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            full     <= (count_next == (ADDR_W+1)'(DEPTH));
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
            if (launch) begin
                tx_data  <= mem[rd_ptr];
                tx_start <= 1'b1;
            end else if (pop) begin
                tx_start <= 1'b0;
            end
            if (gap_load)           gap_cnt <= GW'(GAP);
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a behavioural UART and queue model
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int GAP    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full, empty, overflow, tx_start;
    logic [ADDR_W:0]   count;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              uart_force = 1'b0;
    logic              model_busy;
    logic              uart_en = 1'b0;
    logic              gap_chk = 1'b0;
    int                dly_min = 2, dly_max = 2, hold_min = 20, hold_max = 20;
    int                checks = 0, failures = 0;
    logic [7:0]        exp_q[$];
    logic [7:0]        rx_q[$];

    logic              p_start = 1'b0, p_busy = 1'b0, had_fall = 1'b0;
    logic [7:0]        p_data = 8'h00;
    int                since = 0;

    assign tx_busy = uart_force | model_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    // UART: accepts a request after a random delay, then stays busy for a random time.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_en && tx_start === 1'b1) begin
                repeat (int'($urandom_range(dly_max, dly_min)) - 1) @(negedge clk);
                model_busy = 1'b1;
                repeat (int'($urandom_range(hold_max, hold_min))) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            since++;
            if (p_busy && !tx_busy) begin
                since    = 0;
                had_fall = 1'b1;
            end
            if (!p_start && tx_start) begin
                rx_q.push_back(tx_data);
                if (gap_chk && had_fall) begin
                    checks++;
                    if (since <= GAP) begin
                        failures++;
                        $display("FAIL gap idle_clocks=%0d required>%0d", since, GAP);
                    end
                end
            end
            if (p_start && tx_start) begin
                checks++;
                if (tx_data !== p_data) begin
                    failures++;
                    $display("FAIL tx_data_hold got=%h required=%h", tx_data, p_data);
                end
            end
            if (p_start && tx_busy && !p_busy) begin
                checks++;
                if (tx_start !== 1'b0) begin
                    failures++;
                    $display("FAIL start_deassert tx_start=%b required=0", tx_start);
                end
            end
            p_start = tx_start;
            p_busy  = tx_busy;
            p_data  = tx_data;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
        had_fall = 1'b0;
    endtask

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            tx_start !== 1'b0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_values count=%0d empty=%b full=%b ovf=%b start=%b data=%h required 0/1/0/0/0/00",
                     count, empty, full, overflow, tx_start, tx_data);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL post_reset count=%0d empty=%b start=%b required 0/1/0", count, empty, tx_start);
        end
    endtask

    task automatic test_basic();
        do_reset();
        uart_en = 1'b1; dly_min = 2; dly_max = 2; hold_min = 20; hold_max = 20;
        gap_chk = 1'b1;
        wr_en = 1'b1; wr_data = 8'h11; exp_q.push_back(8'h11);
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0 || empty !== 1'b0 || count !== 5'd1) begin
            failures++;
            $display("FAIL latency_n1 start=%b empty=%b count=%0d required 0/0/1", tx_start, empty, count);
        end
        wr_data = 8'h22; exp_q.push_back(8'h22);
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h11) begin
            failures++;
            $display("FAIL latency_n2 start=%b data=%h required 1/11", tx_start, tx_data);
        end
        wr_data = 8'h33; exp_q.push_back(8'h33);
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx(3, 400);
        repeat (40) @(negedge clk);
        checks++;
        if (rx_q.size() != 3) begin
            failures++;
            $display("FAIL basic_len got=%0d required=3", rx_q.size());
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_order idx=%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL basic_end count=%0d empty=%b required 0/1", count, empty);
        end
        gap_chk = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        uart_force = 1'b1;
        uart_en = 1'b1; dly_min = 2; dly_max = 2; hold_min = 3; hold_max = 3;
        for (int i = 0; i < DEPTH; i++) put(8'(i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL full_state full=%b count=%0d start=%b required 1/16/0", full, count, tx_start);
        end
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL overflow_pulse ovf=%b count=%0d required 1/16", overflow, count);
        end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_width ovf=%b required 0", overflow);
        end
        uart_force = 1'b0;
        wait_rx(DEPTH, 2000);
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q.size() != DEPTH) begin
            failures++;
            $display("FAIL overflow_len got=%0d required=%0d", rx_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL overflow_order idx=%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_busy_idle();
        logic bad = 1'b0;
        uart_force = 1'b1;
        do_reset();
        uart_en = 1'b1; dly_min = 2; dly_max = 2; hold_min = 5; hold_max = 5;
        put(8'h5A);
        repeat (10) begin
            @(negedge clk);
            if (tx_start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL busy_block tx_start went high required 0");
        end
        uart_force = 1'b0;
        for (int i = 0; i < 2 && tx_start !== 1'b1; i++) @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL busy_release start=%b data=%h required 1/5a", tx_start, tx_data);
        end
        wait_rx(1, 50);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_hold();
        logic bad = 1'b0;
        do_reset();
        uart_en = 1'b1; dly_min = 100; dly_max = 100; hold_min = 5; hold_max = 5;
        put(8'hC3);
        for (int i = 0; i < 5 && tx_start !== 1'b1; i++) @(negedge clk);
        repeat (95) begin
            @(negedge clk);
            if (tx_start !== 1'b1 || tx_data !== 8'hC3 || count !== 5'd1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL hold_stable start=%b data=%h count=%0d required 1/c3/1", tx_start, tx_data, count);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || rx_q.size() != 1) begin
            failures++;
            $display("FAIL hold_pop count=%0d empty=%b sent=%0d required 0/1/1", count, empty, rx_q.size());
        end
    endtask

    task automatic test_coincident();
        do_reset();
        uart_en = 1'b0;
        for (int i = 0; i < 5; i++) put(8'($urandom));
        @(negedge clk);
        checks++;
        if (count !== 5'd5 || tx_start !== 1'b1) begin
            failures++;
            $display("FAIL coinc_setup count=%0d start=%b required 5/1", count, tx_start);
        end
        uart_force = 1'b1;
        wr_en = 1'b1; wr_data = 8'($urandom); exp_q.push_back(wr_data);
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd5 || tx_start !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL coinc_count count=%0d start=%b required 5/0", count, tx_start);
        end
        uart_force = 1'b0;
        uart_en = 1'b1; dly_min = 1; dly_max = 3; hold_min = 2; hold_max = 5;
        wait_rx(6, 400);
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q.size() != 6) begin
            failures++;
            $display("FAIL coinc_len got=%0d required=6", rx_q.size());
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL coinc_order idx=%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int t = 0;
        do_reset();
        uart_en = 1'b1; dly_min = 1; dly_max = 4; hold_min = 1; hold_max = 8;
        gap_chk = 1'b1;
        while (n < 40 && t < 3000) begin
            if ($urandom_range(1, 0) == 1 && (n - int'(rx_q.size())) < DEPTH - 1) begin
                wr_en   = 1'b1;
                wr_data = 8'(128 + n);
                exp_q.push_back(wr_data);
                n++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        wr_en = 1'b0;
        wait_rx(40, 3000);
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q.size() != 40) begin
            failures++;
            $display("FAIL stream_len got=%0d required=40", rx_q.size());
        end
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stream_order idx=%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL stream_end count=%0d empty=%b required 0/1", count, empty);
        end
        gap_chk = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        int t = 0;
        do_reset();
        uart_en = 1'b1; dly_min = 2; dly_max = 2; hold_min = 30; hold_max = 30;
        for (int i = 0; i < 4; i++) put(8'($urandom));
        while (!(tx_busy === 1'b1 && tx_start === 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (count !== 5'd3) begin
            failures++;
            $display("FAIL mid_setup count=%0d required=3", count);
        end
        reset = 1'b1;
        uart_en = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset count=%0d empty=%b start=%b required 0/1/0", count, empty, tx_start);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || empty !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL mid_after start=%b empty=%b required 0/1", tx_start, empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_busy_idle();
        test_hold();
        test_coincident();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
